// File: rtl/writeback_stage.sv
// Register-file writeback for RV32E: merges single-cycle ALU results with byte-serial load data.
// Optional misaligned-load rejection is enabled by defining WB_ALIGN_CHECK_EN.
module writeback_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [3:0]  alu_rd,
    input  logic [31:0] alu_value,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [3:0]  ld_rd,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic        mem_byte_valid,
    input  logic [7:0]  mem_byte,
    output logic [3:0]  write_register,
    output logic [31:0] write_value,
    output logic        busy,
    output logic        misaligned
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        COMMIT
    } state_t;

    state_t      state;
    logic [3:0]  rd_q;
    logic [2:0]  funct3_q;
    logic [2:0]  byte_count;
    logic [2:0]  bytes_needed;
    logic [31:0] assembled;
    logic [31:0] extended;
    logic [2:0]  accept_need;
    logic        align_reject;

    assign ld_ready  = (state == IDLE);
    assign alu_ready = (state != COMMIT);
    assign busy      = (state != IDLE);

    // A byte count of zero marks an unsupported load type
    always_comb begin
        accept_need = 3'd0;
        case (ld_funct3)
            3'b000, 3'b100: accept_need = 3'd1;
            3'b001, 3'b101: accept_need = 3'd2;
            3'b010:         accept_need = 3'd4;
            default:        accept_need = 3'd0;
        endcase
    end

    always_comb begin
        extended = assembled;
        case (funct3_q)
            3'b000:  extended = {{24{assembled[7]}}, assembled[7:0]};
            3'b100:  extended = {24'h000000, assembled[7:0]};
            3'b001:  extended = {{16{assembled[15]}}, assembled[15:0]};
            3'b101:  extended = {16'h0000, assembled[15:0]};
            default: extended = assembled;
        endcase
    end

`ifdef WB_ALIGN_CHECK_EN
    logic misaligned_q;

    always_comb begin
        align_reject = 1'b0;
        if (accept_need == 3'd2)
            align_reject = ld_offset[0];
        else if (accept_need == 3'd4)
            align_reject = (ld_offset != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            misaligned_q <= 1'b0;
        else
            misaligned_q <= (state == IDLE) && ld_valid && align_reject;
    end

    assign misaligned = misaligned_q;
`else
    logic unused_offset;

    assign unused_offset = ^ld_offset;
    assign align_reject  = 1'b0;
    assign misaligned    = 1'b0;
`endif

    // ALU and load commit never collide: alu_ready is low during COMMIT
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            rd_q           <= 4'd0;
            funct3_q       <= 3'd0;
            byte_count     <= 3'd0;
            bytes_needed   <= 3'd0;
            assembled      <= 32'd0;
            write_register <= 4'd0;
            write_value    <= 32'd0;
        end else begin
            write_register <= 4'd0;
            if (alu_valid && alu_ready) begin
                write_register <= alu_rd;
                write_value    <= alu_value;
            end
            case (state)
                IDLE: begin
                    if (ld_valid) begin
                        rd_q         <= ld_rd;
                        funct3_q     <= ld_funct3;
                        byte_count   <= 3'd0;
                        bytes_needed <= accept_need;
                        assembled    <= 32'd0;
                        if (accept_need != 3'd0 && !align_reject)
                            state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (mem_byte_valid) begin
                        assembled[{byte_count[1:0], 3'b000} +: 8] <= mem_byte;
                        byte_count <= byte_count + 3'd1;
                        if (byte_count + 3'd1 == bytes_needed)
                            state <= COMMIT;
                    end
                end
                COMMIT: begin
                    write_register <= rd_q;
                    write_value    <= extended;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed-vector bench for writeback_stage; define WB_ALIGN_CHECK_EN to exercise alignment rejection.
module tb_writeback_stage;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [3:0]  alu_rd;
    logic [31:0] alu_value;
    logic        ld_valid;
    logic        ld_ready;
    logic [3:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_offset;
    logic        mem_byte_valid;
    logic [7:0]  mem_byte;
    logic [3:0]  write_register;
    logic [31:0] write_value;
    logic        busy;
    logic        misaligned;

    int vectorCount;
    int missCount;

    writeback_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_rd         (alu_rd),
        .alu_value      (alu_value),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_rd          (ld_rd),
        .ld_funct3      (ld_funct3),
        .ld_offset      (ld_offset),
        .mem_byte_valid (mem_byte_valid),
        .mem_byte       (mem_byte),
        .write_register (write_register),
        .write_value    (write_value),
        .busy           (busy),
        .misaligned     (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drives one complete load and checks the commit cycle and the resulting write
    task automatic applyStimulus(input string tag, input logic [3:0] rd, input logic [2:0] f3,
                                 input logic [31:0] data, input int nBytes, input logic [31:0] expVal);
        ld_valid  = 1'b1;
        ld_rd     = rd;
        ld_funct3 = f3;
        ld_offset = 2'b00;
        tick();
        ld_valid = 1'b0;
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
        for (int i = 0; i < nBytes; i++) begin
            mem_byte_valid = 1'b1;
            mem_byte       = data[8*i +: 8];
            tick();
        end
        mem_byte_valid = 1'b0;
        checkOutput({tag, "_commit_alu_ready"}, {31'd0, alu_ready}, 32'd0);
        checkOutput({tag, "_commit_noWrite"}, {28'd0, write_register}, 32'd0);
        tick();
        checkOutput({tag, "_rd"}, {28'd0, write_register}, {28'd0, rd});
        checkOutput({tag, "_value"}, write_value, expVal);
        checkOutput({tag, "_idle"}, {31'd0, ld_ready}, 32'd1);
    endtask

    initial begin
        vectorCount    = 0;
        missCount      = 0;
        rst_n          = 1'b0;
        alu_valid      = 1'b0;
        alu_rd         = 4'd0;
        alu_value      = 32'd0;
        ld_valid       = 1'b0;
        ld_rd          = 4'd0;
        ld_funct3      = 3'd0;
        ld_offset      = 2'd0;
        mem_byte_valid = 1'b0;
        mem_byte       = 8'd0;
        tick();
        tick();
        rst_n = 1'b1;
        checkOutput("reset_wr", {28'd0, write_register}, 32'd0);
        checkOutput("reset_wv", write_value, 32'd0);
        checkOutput("reset_ld_ready", {31'd0, ld_ready}, 32'd1);
        checkOutput("reset_alu_ready", {31'd0, alu_ready}, 32'd1);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_misaligned", {31'd0, misaligned}, 32'd0);

        alu_valid = 1'b1;
        alu_rd    = 4'd5;
        alu_value = 32'hDEADBEEF;
        tick();
        alu_valid = 1'b0;
        checkOutput("alu_rd", {28'd0, write_register}, 32'd5);
        checkOutput("alu_value", write_value, 32'hDEADBEEF);
        tick();
        checkOutput("alu_pulse_end", {28'd0, write_register}, 32'd0);

        applyStimulus("lb", 4'd3, 3'b000, 32'h00000080, 1, 32'hFFFFFF80);
        applyStimulus("lbu", 4'd3, 3'b100, 32'h00000080, 1, 32'h00000080);
        applyStimulus("lh", 4'd4, 3'b001, 32'h0000FF80, 2, 32'hFFFFFF80);
        applyStimulus("lhu", 4'd4, 3'b101, 32'h0000FF80, 2, 32'h0000FF80);
        applyStimulus("lw", 4'd7, 3'b010, 32'h12345678, 4, 32'h12345678);
        applyStimulus("lb_pos", 4'd6, 3'b000, 32'h0000007F, 1, 32'h0000007F);
        applyStimulus("lb_rd0", 4'd0, 3'b000, 32'h000000AA, 1, 32'hFFFFFFAA);

        // ALU result slipped in between LW bytes 1 and 2
        ld_valid  = 1'b1;
        ld_rd     = 4'd7;
        ld_funct3 = 3'b010;
        tick();
        ld_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_byte_valid = 1'b1;
            mem_byte       = 8'h11 * (i + 1);
            tick();
        end
        mem_byte_valid = 1'b0;
        checkOutput("mix_alu_ready_collect", {31'd0, alu_ready}, 32'd1);
        alu_valid = 1'b1;
        alu_rd    = 4'd2;
        alu_value = 32'hCAFEF00D;
        tick();
        alu_valid = 1'b0;
        checkOutput("mix_alu_rd", {28'd0, write_register}, 32'd2);
        checkOutput("mix_alu_value", write_value, 32'hCAFEF00D);
        checkOutput("mix_busy", {31'd0, busy}, 32'd1);
        for (int i = 2; i < 4; i++) begin
            mem_byte_valid = 1'b1;
            mem_byte       = 8'h11 * (i + 1);
            tick();
        end
        mem_byte_valid = 1'b0;
        checkOutput("mix_commit_alu_ready", {31'd0, alu_ready}, 32'd0);
        tick();
        checkOutput("mix_lw_rd", {28'd0, write_register}, 32'd7);
        checkOutput("mix_lw_value", write_value, 32'h44332211);
        checkOutput("mix_after_alu_ready", {31'd0, alu_ready}, 32'd1);

        // Reset in the middle of a load
        ld_valid  = 1'b1;
        ld_rd     = 4'd8;
        ld_funct3 = 3'b010;
        tick();
        ld_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_byte_valid = 1'b1;
            mem_byte       = 8'hA0 + 8'(i);
            tick();
        end
        mem_byte_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("abort_wr", {28'd0, write_register}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_ld_ready", {31'd0, ld_ready}, 32'd1);
        tick();
        checkOutput("abort_noWrite", {28'd0, write_register}, 32'd0);
        applyStimulus("post_abort_lb", 4'd9, 3'b000, 32'h000000F0, 1, 32'hFFFFFFF0);

        // Unsupported funct3 is accepted but never leaves IDLE
        ld_valid  = 1'b1;
        ld_rd     = 4'd10;
        ld_funct3 = 3'b011;
        tick();
        ld_valid = 1'b0;
        checkOutput("bad_f3_busy", {31'd0, busy}, 32'd0);
        mem_byte_valid = 1'b1;
        mem_byte       = 8'h55;
        tick();
        mem_byte_valid = 1'b0;
        tick();
        checkOutput("bad_f3_noWrite", {28'd0, write_register}, 32'd0);
        checkOutput("bad_f3_idle", {31'd0, ld_ready}, 32'd1);

`ifdef WB_ALIGN_CHECK_EN
        ld_valid  = 1'b1;
        ld_rd     = 4'd11;
        ld_funct3 = 3'b010;
        ld_offset = 2'd2;
        tick();
        ld_valid  = 1'b0;
        ld_offset = 2'd0;
        checkOutput("mis_lw_pulse", {31'd0, misaligned}, 32'd1);
        checkOutput("mis_lw_ld_ready", {31'd0, ld_ready}, 32'd1);
        checkOutput("mis_lw_noWrite", {28'd0, write_register}, 32'd0);
        mem_byte_valid = 1'b1;
        mem_byte       = 8'h77;
        tick();
        mem_byte_valid = 1'b0;
        checkOutput("mis_lw_pulse_end", {31'd0, misaligned}, 32'd0);
        checkOutput("mis_lw_busy", {31'd0, busy}, 32'd0);
        tick();
        checkOutput("mis_lw_noWrite2", {28'd0, write_register}, 32'd0);
        ld_valid  = 1'b1;
        ld_rd     = 4'd12;
        ld_funct3 = 3'b101;
        ld_offset = 2'd1;
        tick();
        ld_valid  = 1'b0;
        ld_offset = 2'd0;
        checkOutput("mis_lhu_pulse", {31'd0, misaligned}, 32'd1);
        checkOutput("mis_lhu_busy", {31'd0, busy}, 32'd0);
`else
        ld_valid  = 1'b1;
        ld_rd     = 4'd11;
        ld_funct3 = 3'b010;
        ld_offset = 2'd2;
        tick();
        ld_valid  = 1'b0;
        ld_offset = 2'd0;
        checkOutput("offset_ignored_busy", {31'd0, busy}, 32'd1);
        checkOutput("offset_ignored_misaligned", {31'd0, misaligned}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            mem_byte_valid = 1'b1;
            mem_byte       = 8'hC0 + 8'(i);
            tick();
        end
        mem_byte_valid = 1'b0;
        tick();
        checkOutput("offset_ignored_rd", {28'd0, write_register}, 32'd11);
        checkOutput("offset_ignored_value", write_value, 32'hC3C2C1C0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Sole writer of the register file's write port (`write_register`, `write_value`).
- Merges two sources: single-cycle ALU results, and load data from the byte-serial memory interface.
- Load data arrives one byte per handshake, little-endian. The stage assembles it and sign- or zero-extends it per RV32E load type.
- It then issues a one-cycle write. `write_register` = 0 means no write, because register 0 is immutable.

Parameters:
- none (RV32E: fixed 4-bit register index, 32-bit data)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- alu_valid  in  1  ALU result present this cycle
- alu_ready  out  1  stage can accept an ALU result this cycle
- alu_rd  in  4  ALU destination register
- alu_value  in  32  ALU result
- ld_valid  in  1  load request
- ld_ready  out  1  stage can accept a load request
- ld_rd  in  4  load destination register
- ld_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- ld_offset  in  2  low address bits (used only by the optional feature)
- mem_byte_valid  in  1  memory byte present
- mem_byte  in  8  memory byte
- write_register  out  4  register file write index (0 = no write)
- write_value  out  32  register file write data
- busy  out  1  load in progress (state != IDLE)
- misaligned  out  1  misaligned-load pulse (0 when the optional feature is absent)

Behaviour:
- Reset (rst_n = 0 at posedge clk): state IDLE; `write_register`=0, `write_value`=0, `misaligned`=0, byte count 0, assembled value 0.
- Reset outputs: `ld_ready`=1, `alu_ready`=1, `busy`=0. Reset mid-load aborts the load with no write.
- States:
  - IDLE: no load pending.
  - COLLECT: receiving load bytes.
  - COMMIT: assembled load value ready to write.
- `ld_ready` = (state == IDLE). `alu_ready` = (state != COMMIT). `busy` = (state != IDLE).
- Outputs are registered. Every cycle, `write_register` defaults to 0; a write is a one-cycle pulse.
- ALU path:
  - On a posedge with `alu_valid` & `alu_ready`: `write_register` <= `alu_rd`, `write_value` <= `alu_value`.
  - Latency is 1 cycle. Accepted in IDLE and COLLECT.
- Load accept (IDLE, `ld_valid` high):
  - Latch `ld_rd` and `ld_funct3`; clear byte count and assembled value.
  - Byte count needed: 1 for LB/LBU, 2 for LH/LHU, 4 for LW.
  - Next state COLLECT.
  - Invalid `ld_funct3` (011, 110, 111): accepted, stays IDLE, never writes.
- Simultaneous ALU result and load accept in IDLE: both are taken. The ALU write issues next cycle; the load proceeds.
- COLLECT:
  - On each `mem_byte_valid`, byte k (k = 0..3) is placed in bits [8k+7:8k]; count increments.
  - The cycle the final byte arrives, next state is COMMIT.
  - Bytes are ignored in IDLE and COMMIT.
- COMMIT (exactly 1 cycle):
  - `write_register` <= latched rd, `write_value` <= extended value; next state IDLE.
  - `alu_ready` is 0 in COMMIT, so the port never conflicts.
- Extension:
  - LB sign-extends bit 7; LBU zero-extends bit 7.
  - LH sign-extends bit 15; LHU zero-extends bit 15.
  - LW uses all 32 bits.
- Load with rd = 0: full sequence runs; output index is 0, so no effective write.
- Load latency: write visible on the cycle after COMMIT. For LB, that is 2 cycles after the byte handshake.

Optional Feature:
- Macro: `WB_ALIGN_CHECK_EN`.
- Defined: at load accept, LH/LHU with `ld_offset[0]`=1, or LW with `ld_offset` != 0, is rejected.
  - Rejection: `misaligned` pulses 1 for one cycle, state stays IDLE, no bytes consumed, no write.
- Not defined: `ld_offset` is ignored, `misaligned` is tied 0, and all loads proceed.

Test Plan:
1. Reset, then `alu_valid`=1, `alu_rd`=5, `alu_value`=0xDEADBEEF for 1 cycle -> next cycle `write_register`=5, `write_value`=0xDEADBEEF; the following cycle `write_register`=0.
2. LB rd=3, byte 0x80 -> `write_register`=3, `write_value`=0xFFFFFF80. LBU with the same byte -> 0x00000080.
3. LH rd=4, bytes 0x80, 0xFF -> 0xFFFFFF80. LHU with the same bytes -> 0x0000FF80. LW rd=7, bytes 0x78, 0x56, 0x34, 0x12 -> 0x12345678.
4. ALU write of rd=2 between LW bytes 1 and 2 -> rd=2 written immediately. LW result is unaffected; `alu_ready`=0 only in the COMMIT cycle.
5. rst_n low after 2 of 4 LW bytes -> no write; `busy`=0, `ld_ready`=1. A new LB then completes correctly.
6. With `WB_ALIGN_CHECK_EN` defined: LW with `ld_offset`=2 -> `misaligned` pulses 1 for one cycle, no write, `ld_ready` stays 1.
